// File: rtl/huffman_pkg.sv
// rtl/huffman_pkg.sv - shared Huffman link definitions (symbols, table fields, decoder states)
package huffman_pkg;

  localparam logic [3:0] SYM_A = 4'hA;
  localparam logic [3:0] SYM_B = 4'hB;
  localparam logic [3:0] SYM_C = 4'hC;
  localparam logic [3:0] SYM_D = 4'hD;

  localparam int NUM_SYMS = 4;
  localparam int LEN_W    = 2;
  localparam int CODE_W   = 3;
  localparam int ENTRY_W  = LEN_W + CODE_W;
  localparam int TABLE_W  = NUM_SYMS * ENTRY_W;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_EMIT   = 3'd2,
    ST_FINISH = 3'd3,
    ST_ERR    = 3'd4
  } state_e;

  // Table entry i always describes symbol SYM_A + i.
  function automatic logic [3:0] sym_of(input logic [1:0] idx);
    return SYM_A + {2'b00, idx};
  endfunction

endpackage

// File: rtl/huffman_code_match.sv
// rtl/huffman_code_match.sv - combinational lookup of a candidate codeword in the code table
module huffman_code_match
  import huffman_pkg::*;
#(
  parameter int MAX_LEN = 3
) (
  input  logic [TABLE_W-1:0] code_table,
  input  logic [CODE_W-1:0]  cand_code,
  input  logic [LEN_W-1:0]   cand_len,
  output logic               hit,
  output logic [1:0]         sym_idx
);

  logic [CODE_W-1:0] mask;

  always_comb begin
    mask = '0;
    for (int b = 0; b < CODE_W; b++) begin
      mask[b] = (b < int'(cand_len));
    end
  end

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    logic [LEN_W-1:0]  ent_len;
    logic [CODE_W-1:0] ent_code;
    hit      = 1'b0;
    sym_idx  = '0;
    ent_len  = '0;
    ent_code = '0;
    for (int e = NUM_SYMS - 1; e >= 0; e--) begin
      ent_len  = code_table[e*ENTRY_W+CODE_W +: LEN_W];
      ent_code = code_table[e*ENTRY_W +: CODE_W];
      if ((ent_len != '0) && (int'(ent_len) <= MAX_LEN) && (ent_len == cand_len) &&
          ((ent_code & mask) == (cand_code & mask))) begin
        hit     = 1'b1;
        sym_idx = 2'(e);
      end
    end
  end

endmodule

// File: rtl/huffman_decode.sv
// rtl/huffman_decode.sv - serial MSB-first Huffman decoder with string reassembly
module huffman_decode
  import huffman_pkg::*;
#(
  parameter int NUM_CHARS = 7,
  parameter int MAX_LEN   = 3
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   START,
  input  logic [TABLE_W-1:0]     CODE_TABLE,
  input  logic                   BIT_IN,
  input  logic                   BIT_VALID,
  output logic                   BIT_READY,
  output logic [3:0]             CHAR_OUT,
  output logic                   CHAR_VALID,
  output logic [4*NUM_CHARS-1:0] CHARACTER_OUT,
  output logic                   DONE,
  output logic                   ERROR
);

  localparam int IDX_W = $clog2(NUM_CHARS);

  state_e                 state_q, state_d;
  logic [MAX_LEN-1:0]     sr_q, sr_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [TABLE_W-1:0]     table_q, table_d;
  logic [1:0]             sym_q, sym_d;
  logic [4*NUM_CHARS-1:0] chars_q, chars_d;

  logic [MAX_LEN-1:0] new_code;
  logic [LEN_W-1:0]   new_len;
  logic               hit;
  logic [1:0]         hit_idx;

  assign new_code = {sr_q[MAX_LEN-2:0], BIT_IN};
  assign new_len  = len_q + LEN_W'(1);

  huffman_code_match #(
    .MAX_LEN (MAX_LEN)
  ) u_match (
    .code_table (table_q),
    .cand_code  (CODE_W'(new_code)),
    .cand_len   (new_len),
    .hit        (hit),
    .sym_idx    (hit_idx)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      table_q <= '0;
      sym_q   <= '0;
      chars_q <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      table_q <= table_d;
      sym_q   <= sym_d;
      chars_q <= chars_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    len_d      = len_q;
    idx_d      = idx_q;
    table_d    = table_q;
    sym_d      = sym_q;
    chars_d    = chars_q;
    BIT_READY  = 1'b0;
    CHAR_VALID = 1'b0;
    CHAR_OUT   = '0;
    DONE       = 1'b0;
    ERROR      = 1'b0;

    case (state_q)
      ST_IDLE, ST_FINISH, ST_ERR: begin
        DONE  = (state_q == ST_FINISH);
        ERROR = (state_q == ST_ERR);
        if (START) begin
          sr_d    = '0;
          len_d   = '0;
          idx_d   = '0;
          chars_d = '0;
          table_d = CODE_TABLE;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        BIT_READY = 1'b1;
        if (BIT_VALID) begin
          if (hit) begin
            // String slot is written here so it is already visible alongside CHAR_VALID.
            sym_d                 = hit_idx;
            chars_d[4*idx_q +: 4] = sym_of(hit_idx);
            state_d               = ST_EMIT;
          end else if (int'(new_len) == MAX_LEN) begin
            state_d = ST_ERR;
          end else begin
            sr_d  = new_code;
            len_d = new_len;
          end
        end
      end

      ST_EMIT: begin
        CHAR_VALID = 1'b1;
        CHAR_OUT   = sym_of(sym_q);
        idx_d      = idx_q + IDX_W'(1);
        sr_d       = '0;
        len_d      = '0;
        state_d    = (int'(idx_q) == NUM_CHARS - 1) ? ST_FINISH : ST_SHIFT;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign CHARACTER_OUT = chars_q;

endmodule

// File: doc/huffman_decode.md
# huffman_decode

Serial Huffman decoder for the 4-symbol alphabet (4'hA..4'hD) produced by the frequency-count/code-build front end. It takes a loaded code table and an MSB-first bitstream, and emits one decoded character per codeword. It also reassembles the 7-character string in the same 28-bit packing the encoder consumes, with character 0 in [3:0]. It sits at the receive end of the Huffman link and closes the encode/decode loop for on-chip self-check.

## Interface
- NUM_CHARS, 7: characters decoded per message; sets CHARACTER_OUT width 4*NUM_CHARS.
- MAX_LEN, 3: maximum codeword length in bits (4 leaves give depth ≤ 3).
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- START  in  1  one-cycle pulse: latch CODE_TABLE, begin a message.
- CODE_TABLE  in  20  entry i (symbol 4'hA+i) at [5i+4:5i]: [5i+4:5i+3] = length (0 = unused), [5i+2:5i] = code, right-aligned.
- BIT_IN  in  1  next code bit, MSB of each codeword first.
- BIT_VALID  in  1  BIT_IN is valid.
- BIT_READY  out  1  decoder accepts a bit this cycle.
- CHAR_OUT  out  4  decoded symbol; meaningful only while CHAR_VALID is high.
- CHAR_VALID  out  1  one-cycle pulse per decoded character.
- CHARACTER_OUT  out  4*NUM_CHARS  reassembled string; character k at [4k+3:4k].
- DONE  out  1  NUM_CHARS characters decoded; held.
- ERROR  out  1  no codeword matched within MAX_LEN bits; held.

## Operation
- States: IDLE, SHIFT, EMIT, FINISH, ERR.
- Reset (any state, any cycle): state IDLE; all outputs 0; shift register, bit length, char index and table cleared.
- IDLE: BIT_READY=0. START moves to SHIFT. START clears the shift register, bit length, char index and CHARACTER_OUT, and latches CODE_TABLE.
- SHIFT: BIT_READY=1. On BIT_VALID&BIT_READY, the new code is {sr,BIT_IN} with length len+1. It is compared combinationally against all 4 entries. An entry matches when its length equals len+1 and its low len+1 code bits equal the new code.
  - On a match, the symbol is latched and the state goes to EMIT. If several entries match, the lowest index wins.
  - With no match and len+1 == MAX_LEN, the state goes to ERR.
  - Otherwise sr and len are updated and the state stays in SHIFT.
- EMIT: BIT_READY=0. CHAR_VALID=1 and CHAR_OUT=symbol. The symbol is written to CHARACTER_OUT[4*idx+:4] and idx increments. sr and len clear.
  - If idx == NUM_CHARS-1, go to FINISH; else go to SHIFT.
- FINISH: DONE=1 and BIT_READY=0.
- ERR: ERROR=1 and BIT_READY=0. CHARACTER_OUT holds the characters decoded so far.
- START is honoured in IDLE, FINISH and ERR; it clears DONE/ERROR and restarts. START is ignored in SHIFT and EMIT.
- Table entries of length 0 never match. Entries of length > MAX_LEN never match.
- Idx is $clog2(NUM_CHARS) bits wide; len is 2 bits; the shift register is MAX_LEN bits.

## Timing
- START at edge t: BIT_READY=1 from cycle t+1.
- Final bit of a codeword accepted at edge n: CHAR_VALID and the CHARACTER_OUT update are visible after edge n+1. BIT_READY=0 in that cycle, so there is a one-bubble gap per character.
- The last character's EMIT is followed by DONE=1 the next cycle.
- The offending bit accepted at edge n gives ERROR=1 after edge n+1.
- BIT_VALID gaps stall SHIFT with no state change.
- Peak throughput is 1 bit/cycle.

## Structure
- Shared Huffman package holds:
  - symbol constants SYM_A..SYM_D = 4'hA..4'hD;
  - entry field widths (LEN_W=2, CODE_W=3, ENTRY_W=5);
  - state encoding.
- The encoder side reuses the same package.
- One natural sub-module: huffman_code_match. It is combinational: inputs are the table, the candidate code and its length; outputs are hit and symbol index, with priority to the lowest index.

## Test plan
- Normal message: table A=110/3, B=10/2, C=111/3, D=0/1. Stream 0,1,0,0,0,1,1,1,1,1,0,1,0 with BIT_VALID constant. Required: CHAR_VALID pulses give D,B,D,D,C,A,B; CHARACTER_OUT=28'hBACDDBD; DONE=1; ERROR=0.
- Stalled stream: same message with BIT_VALID toggled 1/0 every cycle. Required: identical outputs, no bit lost or duplicated.
- Error: table D=0/1, A..C length 0; stream 1,1,1. Required: ERROR=1 one cycle after the 3rd bit; no CHAR_VALID pulses; BIT_READY=0.
- Reset mid-message: assert nRST low after 3 characters. Required: all outputs 0 immediately. A following START and full stream decode correctly.
- Restart: pulse START in FINISH with a new table A=0/1, B=10/2, C=110/3, D=111/3, then stream of seven 0 bits. Required: DONE clears, then CHARACTER_OUT=28'hAAAAAAA, DONE=1.
- START ignored mid-message: pulse START during SHIFT of the normal message. Required: the result is unchanged, 28'hBACDDBD.
